alu_arbiter: RTL and testbench

- Shares one combinational ALU datapath between two requesters, e.g. the execute stage (port 0) and the branch-compare path (port 1).
- Each requester hands over an ALU control code and two operands with a valid/ready handshake.
- The arbiter grants one requester, holds the operands on the ALU for a fixed number of cycles, registers the result, and returns it with a response handshake tagged by requester id.

---
 rtl/alu_arbiter_if.sv | 46 ++++
 rtl/alu_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bus bundle for alu_arbiter: two requester handshakes, ALU drive/return and the tagged response channel.
// Requester-side/environment view is the master modport; the arbiter uses the slave modport.
`ifndef ALU_CTL_WIDTH
`define ALU_CTL_WIDTH 4
`endif

interface alu_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int CTL_W = `ALU_CTL_WIDTH
);
    logic             req0_valid;
    logic             req0_ready;
    logic [CTL_W-1:0] req0_ctl;
    logic [XLEN-1:0]  req0_a;
    logic [XLEN-1:0]  req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [CTL_W-1:0] req1_ctl;
    logic [XLEN-1:0]  req1_a;
    logic [XLEN-1:0]  req1_b;
    logic [CTL_W-1:0] alu_ctl;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  alu_res;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [XLEN-1:0]  rsp_data;
    logic             busy;

    modport master (
        output req0_valid, req0_ctl, req0_a, req0_b,
        output req1_valid, req1_ctl, req1_a, req1_b,
        output alu_res, rsp_ready,
        input  req0_ready, req1_ready, alu_ctl, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req0_valid, req0_ctl, req0_a, req0_b,
        input  req1_valid, req1_ctl, req1_a, req1_b,
        input  alu_res, rsp_ready,
        output req0_ready, req1_ready, alu_ctl, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU; holds operands ALU_LAT cycles, returns a tagged result.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) instead of round-robin.
`ifndef ALU_CTL_WIDTH
`define ALU_CTL_WIDTH 4
`endif

module alu_arbiter #(
    parameter int XLEN    = 32,
    parameter int CTL_W   = `ALU_CTL_WIDTH,
    parameter int ALU_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_check
        $error("alu_arbiter: ALU_LAT must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_last_grant;
    logic [3:0]       r_cnt;
    logic [CTL_W-1:0] r_alu_ctl;
    logic [XLEN-1:0]  r_alu_a;
    logic [XLEN-1:0]  r_alu_b;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [XLEN-1:0]  r_rsp_data;

    logic             w_any_valid;
    logic             w_grant;
    logic             w_accept;
    logic             w_rsp_hs;
    logic             w_cnt_zero;
    logic [CTL_W-1:0] w_sel_ctl;
    logic [XLEN-1:0]  w_sel_a;
    logic [XLEN-1:0]  w_sel_b;

    // Grant selection among valid requesters
    always_comb begin
        w_any_valid = bus.req0_valid | bus.req1_valid;
        w_grant     = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (bus.req0_valid) begin
            w_grant = 1'b0;
        end else begin
            w_grant = 1'b1;
        end
`else
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
`endif
    end

    assign w_accept   = (r_state == IDLE) && w_any_valid && !rst;
    assign w_rsp_hs   = r_rsp_valid && bus.rsp_ready;
    assign w_cnt_zero = (r_cnt == 4'd0);
    assign w_sel_ctl  = w_grant ? bus.req1_ctl : bus.req0_ctl;
    assign w_sel_a    = w_grant ? bus.req1_a   : bus.req0_a;
    assign w_sel_b    = w_grant ? bus.req1_b   : bus.req0_b;

    assign bus.req0_ready = w_accept && !w_grant;
    assign bus.req1_ready = w_accept &&  w_grant;
    assign bus.busy       = (r_state != IDLE);
    assign bus.alu_ctl    = r_alu_ctl;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_data   = r_rsp_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = EXEC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            EXEC: begin
                if (w_cnt_zero) begin
                    w_next_state = RESP;
                end else begin
                    w_next_state = EXEC;
                end
            end
            RESP: begin
                if (w_rsp_hs) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RESP;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand latch, latency countdown and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            r_alu_ctl    <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_ctl <= w_sel_ctl;
                        r_alu_a   <= w_sel_a;
                        r_alu_b   <= w_sel_b;
                        r_rsp_id  <= w_grant;
                        r_cnt     <= LAT_M1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_grant;
`endif
                    end
                end
                EXEC: begin
                    // Counter reaching zero marks the last cycle the operands sit on the ALU
                    if (w_cnt_zero) begin
                        r_rsp_data  <= bus.alu_res;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: reference model predicts grants/readies and queues expected responses;
// a separate monitor pops and compares each presented response.
`ifndef ALU_CTL_WIDTH
`define ALU_CTL_WIDTH 4
`endif

module tb_alu_arbiter;
    localparam int XLEN  = 32;
    localparam int CTL_W = `ALU_CTL_WIDTH;
    localparam int LAT   = 3;

    localparam logic [CTL_W-1:0] OP_ADD  = CTL_W'(0);
    localparam logic [CTL_W-1:0] OP_SUB  = CTL_W'(1);
    localparam logic [CTL_W-1:0] OP_AND  = CTL_W'(2);
    localparam logic [CTL_W-1:0] OP_OR   = CTL_W'(3);
    localparam logic [CTL_W-1:0] OP_XOR  = CTL_W'(4);
    localparam logic [CTL_W-1:0] OP_SLTU = CTL_W'(5);

    typedef struct {
        logic             id;
        logic [XLEN-1:0]  data;
        int               issue;
        logic [CTL_W-1:0] ctl;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
    } exp_t;

    typedef struct {
        logic [CTL_W-1:0] ctl;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
    } req_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;
    int   n_rsp;

    exp_t sb_q[$];
    req_t pq0[$];
    req_t pq1[$];

    alu_arbiter_if #(.XLEN(XLEN), .CTL_W(CTL_W)) bif ();

    alu_arbiter #(.XLEN(XLEN), .CTL_W(CTL_W), .ALU_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    function automatic logic [XLEN-1:0] alu_fn(input logic [CTL_W-1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign bif.alu_res = alu_fn(bif.alu_ctl, bif.alu_a, bif.alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: arbitration, readiness, busy and operand hold
    logic m_busy;
    logic m_last;
    logic m_g;
    logic m_hs;
    exp_t m_cur;

    initial begin
        m_busy = 1'b0;
        m_last = 1'b1;
        m_cur  = '{id: 1'b0, data: '0, issue: 0, ctl: '0, a: '0, b: '0};
    end

    always @(negedge clk) begin
        if (rst) begin
            check("ready0_in_reset", bif.req0_ready, 1'b0);
            check("ready1_in_reset", bif.req1_ready, 1'b0);
            m_busy = 1'b0;
            m_last = 1'b1;
            sb_q.delete();
        end else begin
            check("busy", bif.busy, m_busy);
            m_hs = !m_busy && (bif.req0_valid || bif.req1_valid);
`ifdef ALU_ARB_FIXED_PRIO_EN
            m_g = bif.req0_valid ? 1'b0 : 1'b1;
`else
            if (bif.req0_valid && bif.req1_valid) m_g = ~m_last;
            else m_g = bif.req1_valid;
`endif
            check("req0_ready", bif.req0_ready, m_hs && !m_g);
            check("req1_ready", bif.req1_ready, m_hs && m_g);
            if (m_busy && cyc >= m_cur.issue + 1 && cyc <= m_cur.issue + LAT) begin
                check("alu_ctl_hold", bif.alu_ctl, m_cur.ctl);
                check("alu_a_hold", bif.alu_a, m_cur.a);
                check("alu_b_hold", bif.alu_b, m_cur.b);
            end
            if (m_hs) begin
                m_cur.id    = m_g;
                m_cur.issue = cyc;
                m_cur.ctl   = m_g ? bif.req1_ctl : bif.req0_ctl;
                m_cur.a     = m_g ? bif.req1_a   : bif.req0_a;
                m_cur.b     = m_g ? bif.req1_b   : bif.req0_b;
                m_cur.data  = alu_fn(m_cur.ctl, m_cur.a, m_cur.b);
                sb_q.push_back(m_cur);
                m_busy = 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                m_last = m_g;
`endif
            end else if (m_busy && cyc >= m_cur.issue + LAT + 1 && bif.rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // Response monitor
    logic mon_seen;
    initial mon_seen = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mon_seen = 1'b0;
        end else if (bif.rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", bif.rsp_valid, 1'b0);
            end else begin
                check("rsp_id", bif.rsp_id, sb_q[0].id);
                check("rsp_data", bif.rsp_data, sb_q[0].data);
                if (!mon_seen) begin
                    check("rsp_latency", 64'(cyc - sb_q[0].issue), 64'(LAT + 1));
                    mon_seen = 1'b1;
                    n_rsp++;
                end
                if (bif.rsp_ready) begin
                    void'(sb_q.pop_front());
                    mon_seen = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds each requester's head entry valid until accepted, bounded by max_cycles
    task automatic run_queues(input int max_cycles);
        int n = 0;
        while ((pq0.size() != 0 || pq1.size() != 0) && n < max_cycles) begin
            bif.req0_valid = (pq0.size() != 0);
            if (pq0.size() != 0) begin
                bif.req0_ctl = pq0[0].ctl;
                bif.req0_a   = pq0[0].a;
                bif.req0_b   = pq0[0].b;
            end
            bif.req1_valid = (pq1.size() != 0);
            if (pq1.size() != 0) begin
                bif.req1_ctl = pq1[0].ctl;
                bif.req1_a   = pq1[0].a;
                bif.req1_b   = pq1[0].b;
            end
            @(negedge clk);
            if (bif.req0_valid && bif.req0_ready) void'(pq0.pop_front());
            if (bif.req1_valid && bif.req1_ready) void'(pq1.pop_front());
            @(posedge clk);
            #1;
            n++;
        end
        bif.req0_valid = 1'b0;
        bif.req1_valid = 1'b0;
        check("accept_timeout", 64'(pq0.size() + pq1.size()), 64'd0);
        pq0.delete();
        pq1.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    function automatic req_t mk(input logic [CTL_W-1:0] c, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b);
        req_t r;
        r.ctl = c;
        r.a   = a;
        r.b   = b;
        return r;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        n_rsp = 0;
        rst = 1'b1;
        bif.req0_valid = 1'b0;
        bif.req0_ctl   = '0;
        bif.req0_a     = '0;
        bif.req0_b     = '0;
        bif.req1_valid = 1'b0;
        bif.req1_ctl   = '0;
        bif.req1_a     = '0;
        bif.req1_b     = '0;
        bif.rsp_ready  = 1'b1;

        tick(2);
        @(negedge clk);
        check("rst_rsp_valid", bif.rsp_valid, 1'b0);
        check("rst_rsp_id", bif.rsp_id, 1'b0);
        check("rst_rsp_data", bif.rsp_data, 32'd0);
        check("rst_alu_ctl", bif.alu_ctl, '0);
        check("rst_alu_a", bif.alu_a, 32'd0);
        check("rst_alu_b", bif.alu_b, 32'd0);
        check("rst_busy", bif.busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single ADD on port 0
        pq0.push_back(mk(OP_ADD, 32'd5, 32'd7));
        run_queues(10);
        tick(LAT + 3);

        // Both valid straight out of reset; port 0 queued twice
        do_reset();
        pq0.push_back(mk(OP_SUB, 32'd10, 32'd3));
        pq0.push_back(mk(OP_ADD, 32'd100, 32'd23));
        pq1.push_back(mk(OP_XOR, 32'h0000_00F0, 32'h0000_00FF));
        run_queues(40);
        tick(LAT + 3);

        // SLTU on port 1 with extreme operand
        pq1.push_back(mk(OP_SLTU, 32'd1, 32'hFFFF_FFFF));
        run_queues(10);
        tick(LAT + 3);

        // Response back-pressure with a pending port 0 request
        bif.rsp_ready = 1'b0;
        pq0.push_back(mk(OP_OR, 32'h1234_0000, 32'h0000_5678));
        run_queues(10);
        tick(LAT + 1);
        bif.req0_valid = 1'b1;
        bif.req0_ctl   = OP_AND;
        bif.req0_a     = 32'hFFFF_0F0F;
        bif.req0_b     = 32'h00FF_FFFF;
        tick(5);
        bif.rsp_ready = 1'b1;
        pq0.push_back(mk(OP_AND, 32'hFFFF_0F0F, 32'h00FF_FFFF));
        run_queues(20);
        tick(LAT + 3);

        // Reset in the middle of EXEC, then both valid
        pq1.push_back(mk(OP_ADD, 32'd1, 32'd1));
        run_queues(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        pq0.push_back(mk(OP_SUB, 32'd0, 32'd1));
        pq1.push_back(mk(OP_XOR, 32'hAAAA_AAAA, 32'h5555_5555));
        run_queues(40);
        tick(LAT + 3);

        // Port 0 pulses during RESP and withdraws
        bif.rsp_ready = 1'b0;
        pq1.push_back(mk(OP_ADD, 32'hFFFF_FFFF, 32'd2));
        run_queues(10);
        tick(LAT + 1);
        bif.req0_valid = 1'b1;
        bif.req0_ctl   = OP_ADD;
        bif.req0_a     = 32'd9;
        bif.req0_b     = 32'd9;
        tick(1);
        bif.req0_valid = 1'b0;
        tick(2);
        bif.rsp_ready = 1'b1;
        tick(LAT + 3);

        // Randomized traffic with arbitrary valid drops and back-pressure
        for (int i = 0; i < 600; i++) begin
            bif.req0_valid = ($urandom_range(0, 2) != 0);
            bif.req1_valid = ($urandom_range(0, 2) != 0);
            bif.req0_ctl   = CTL_W'($urandom_range(0, 5));
            bif.req1_ctl   = CTL_W'($urandom_range(0, 5));
            bif.req0_a     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
            bif.req0_b     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
            bif.req1_a     = $urandom;
            bif.req1_b     = $urandom;
            bif.rsp_ready  = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        bif.req0_valid = 1'b0;
        bif.req1_valid = 1'b0;
        bif.rsp_ready  = 1'b1;
        tick(LAT + 6);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        check("responses_seen", 64'(n_rsp >= 10), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
